multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//   Multicycle control unit driving the datapath's control inputs (reg write, imm select, ALU src/op,
//   mem write, result select) and PC/IR strobes. Decodes opcode/funct fields from the latched IR,
//   sequences each instruction over 3-5 states, stalls on a shared instr/data memory ready handshake.
//   Sits directly upstream of the core datapath.
// PARAMETERS
//   TIMEOUT   255  max stall cycles waiting for i_mem_ready before bus error; 0 disables check
//   CNT_W     8    width of stall counter; must hold TIMEOUT
// PORTS
//   i_clk          in   1  clock, rising edge
//   i_rst          in   1  reset, asynchronous, active-low
//   i_op           in   7  instr[6:0]
//   i_funct3       in   3  instr[14:12]
//   i_funct7_5     in   1  instr[30]
//   i_zero         in   1  ALU zero flag
//   i_mem_ready    in   1  memory completed access this cycle
//   o_pc_write     out  1  load PC
//   o_ir_write     out  1  load IR / old-PC
//   o_adr_src      out  1  0=PC, 1=ALUOut as mem address
//   o_mem_write    out  1  store strobe
//   o_reg_write    out  1  register file write
//   o_imm_src      out  2  00=I 01=S 10=B 11=J
//   o_alu_src_a    out  2  00=PC 01=oldPC 10=rs1
//   o_alu_src_b    out  2  00=rs2 01=imm 10=const 4
//   o_alu_control  out  3  000 add,001 sub,010 and,011 or,101 slt
//   o_result_src   out  2  00=ALUOut 01=mem data 10=ALU result
//   o_illegal      out  1  1-cycle pulse: unsupported opcode in DECODE
//   o_bus_err      out  1  1-cycle pulse: stall exceeded TIMEOUT
// BEHAVIOUR
//   Reset (i_rst=0): state=FETCH, stall cnt=0; all strobes (pc/ir/mem/reg write, illegal, bus_err)=0
//     while reset asserted; other outputs hold FETCH encodings.
//   Outputs Moore-decoded from state, except gating by i_mem_ready/i_zero as noted. Unlisted = 0.
//   FETCH: adr_src=0, src_a=00, src_b=10, add, result_src=10; ir_write=pc_write=i_mem_ready;
//     ready -> DECODE, else stay.
//   DECODE: src_a=01, src_b=01, add (branch target to ALUOut). Next by i_op:
//     0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL,
//     other->FETCH with o_illegal=1.
//   imm_src from i_op in every state: S-type 01, beq 10, jal 11, else 00.
//   MEMADR: src_a=10, src_b=01, add; i_op[5]=0 -> MEMREAD, 1 -> MEMWRITE.
//   MEMREAD: adr_src=1; ready -> MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
//   MEMWRITE: adr_src=1, mem_write=1 held every wait cycle; ready -> FETCH.
//   EXECR: src_a=10, src_b=00; EXECI: src_a=10, src_b=01; ALU op from funct; both -> ALUWB.
//   ALUWB: result_src=00, reg_write=1 -> FETCH.
//   BEQ: src_a=10, src_b=00, sub, result_src=00, pc_write=i_zero -> FETCH.
//   JAL: src_a=01, src_b=10, add, result_src=00, pc_write=1 -> ALUWB (rd=PC+4).
//   Funct decode (EXECR/EXECI): f3 000 -> sub iff op[5]&funct7_5 else add; 010 slt; 110 or;
//     111 and; other f3 -> add, no illegal flag.
//   Stall counter: counts cycles in FETCH/MEMREAD/MEMWRITE with i_mem_ready=0; cleared on any state
//     change. Reaching TIMEOUT: o_bus_err=1 one cycle, state->FETCH, cnt=0, no strobes that cycle.
//   Ready arriving on the timeout cycle wins: normal transition, no bus_err.
//   Async reset mid-instruction aborts immediately; first post-reset state is FETCH.
// TESTING
//   Reset: i_rst=0 mid-MEMWRITE -> mem_write drops same cycle, state=FETCH after release.
//   add R-type (op 0110011,f3 000,f7_5 0), ready=1 -> FETCH,DECODE,EXECR,ALUWB; reg_write only in 4th.
//   lw with ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB reg_write=1,result_src=01.
//   beq i_zero=1 -> pc_write=1 in BEQ; i_zero=0 -> pc_write=0; both return to FETCH.
//   op 1111111 -> o_illegal pulses once in DECODE, next state FETCH, no writes.
//   TIMEOUT=4, ready held 0 in FETCH -> bus_err pulse on 4th stall cycle, cnt reset, FETCH retried.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: sequences each instruction over 3-5 states, decodes the ALU op,
// and stalls on the shared memory's ready handshake, raising a bus error on a stall timeout.
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic [1:0] o_imm_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [2:0] o_alu_control,
    output logic [1:0] o_result_src,
    output logic       o_illegal,
    output logic       o_bus_err
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] stall_cnt;
    logic             stalled;
    logic             timeout_hit;
    logic [2:0]       funct_alu;

    // Only the three memory-facing states wait on the handshake.
    assign stalled     = (state inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !i_mem_ready;
    // The counter holds the stall cycles already spent, so the TIMEOUT-th stall cycle sees TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0) && stalled && (stall_cnt == TIMEOUT_CNT);

    always_comb begin
        unique case (i_funct3)
            3'b000:  funct_alu = (i_op[5] && i_funct7_5) ? 3'b001 : 3'b000;
            3'b010:  funct_alu = 3'b101;
            3'b110:  funct_alu = 3'b011;
            3'b111:  funct_alu = 3'b010;
            default: funct_alu = 3'b000;
        endcase
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            S_FETCH:    if (i_mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                unique case (i_op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BEQ:            next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
                    default:           next_state = S_FETCH;
                endcase
            end
            S_MEMADR:          next_state = i_op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:         if (i_mem_ready) next_state = S_MEMWB;
            S_MEMWRITE:        if (i_mem_ready) next_state = S_FETCH;
            S_EXECR, S_EXECI:  next_state = S_ALUWB;
            S_JAL:             next_state = S_ALUWB;
            default:           next_state = S_FETCH;
        endcase
        if (timeout_hit) next_state = S_FETCH;
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= S_FETCH;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (stalled && !timeout_hit) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    always_comb begin
        o_pc_write    = 1'b0;
        o_ir_write    = 1'b0;
        o_adr_src     = 1'b0;
        o_mem_write   = 1'b0;
        o_reg_write   = 1'b0;
        o_alu_src_a   = 2'b00;
        o_alu_src_b   = 2'b00;
        o_alu_control = 3'b000;
        o_result_src  = 2'b00;
        o_illegal     = 1'b0;
        o_bus_err     = 1'b0;
        unique case (i_op)
            OP_STORE: o_imm_src = 2'b01;
            OP_BEQ:   o_imm_src = 2'b10;
            OP_JAL:   o_imm_src = 2'b11;
            default:  o_imm_src = 2'b00;
        endcase
        unique case (state)
            S_FETCH: begin
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
                o_illegal   = !(i_op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL});
            end
            S_MEMADR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEMREAD:  o_adr_src = 1'b1;
            S_MEMWB: begin
                o_result_src = 2'b01;
                o_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o_adr_src   = 1'b1;
                o_mem_write = 1'b1;
            end
            S_EXECR: begin
                o_alu_src_a   = 2'b10;
                o_alu_control = funct_alu;
            end
            S_EXECI: begin
                o_alu_src_a   = 2'b10;
                o_alu_src_b   = 2'b01;
                o_alu_control = funct_alu;
            end
            S_ALUWB:    o_reg_write = 1'b1;
            S_BEQ: begin
                o_alu_src_a   = 2'b10;
                o_alu_control = 3'b001;
                o_pc_write    = i_zero;
            end
            S_JAL: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                o_pc_write  = 1'b1;
            end
            default: ;
        endcase
        // A timeout cycle, or any cycle under reset, must not commit anything.
        if (timeout_hit || !i_rst) begin
            o_pc_write  = 1'b0;
            o_ir_write  = 1'b0;
            o_mem_write = 1'b0;
            o_reg_write = 1'b0;
            o_illegal   = 1'b0;
        end
        o_bus_err = timeout_hit && i_rst;
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: the driver queues hand-written expected control
// vectors per cycle, a monitor pops and compares them on the falling edge.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic       pc, ir, adr, mw, rw;
        logic [1:0] imm, sa, sb;
        logic [2:0] alu;
        logic [1:0] res;
        logic       ill, be;
    } outs_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [6:0] i_op = '0;
    logic [2:0] i_funct3 = '0;
    logic       i_funct7_5 = 1'b0;
    logic       i_zero = 1'b0;
    logic       i_mem_ready = 1'b0;
    logic       o_pc_write, o_ir_write, o_adr_src, o_mem_write, o_reg_write;
    logic [1:0] o_imm_src, o_alu_src_a, o_alu_src_b, o_result_src;
    logic [2:0] o_alu_control;
    logic       o_illegal, o_bus_err;

    logic [6:0] cur_op = 7'b0110011;
    logic [2:0] cur_f3 = 3'b000;
    logic       cur_f75 = 1'b0;

    outs_t act;
    outs_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 i_clk = ~i_clk;

    multicycle_ctrl_fsm #(.TIMEOUT(4), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_op(i_op), .i_funct3(i_funct3),
        .i_funct7_5(i_funct7_5), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
        .o_pc_write(o_pc_write), .o_ir_write(o_ir_write), .o_adr_src(o_adr_src),
        .o_mem_write(o_mem_write), .o_reg_write(o_reg_write), .o_imm_src(o_imm_src),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_control(o_alu_control),
        .o_result_src(o_result_src), .o_illegal(o_illegal), .o_bus_err(o_bus_err)
    );

    assign act = {o_pc_write, o_ir_write, o_adr_src, o_mem_write, o_reg_write, o_imm_src,
                  o_alu_src_a, o_alu_src_b, o_alu_control, o_result_src, o_illegal, o_bus_err};

    function automatic outs_t mk(input logic pc, ir, adr, mw, rw, input logic [1:0] imm, sa, sb,
                                 input logic [2:0] alu, input logic [1:0] res, input logic ill, be);
        return {pc, ir, adr, mw, rw, imm, sa, sb, alu, res, ill, be};
    endfunction

    // Expected vectors per state, written out from the control table.
    function automatic outs_t e_fetch(input logic [1:0] imm, input logic rdy, input logic be);
        return mk(rdy, rdy, 0, 0, 0, imm, 2'b00, 2'b10, 3'b000, 2'b10, 0, be);
    endfunction
    function automatic outs_t e_decode(input logic [1:0] imm, input logic ill);
        return mk(0, 0, 0, 0, 0, imm, 2'b01, 2'b01, 3'b000, 2'b00, ill, 0);
    endfunction
    function automatic outs_t e_memadr(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 0, imm, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
    endfunction
    function automatic outs_t e_memwrite(input logic mw, input logic be);
        return mk(0, 0, 1, mw, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0, be);
    endfunction
    function automatic outs_t e_exec(input logic [1:0] sb, input logic [2:0] alu);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, sb, alu, 2'b00, 0, 0);
    endfunction
    function automatic outs_t e_aluwb(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 1, imm, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    endfunction
    function automatic outs_t e_beq(input logic pc);
        return mk(pc, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0);
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        cur_op = op;
        cur_f3 = f3;
        cur_f75 = f75;
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic z, input outs_t e, input string nm);
        @(posedge i_clk);
        #1;
        i_rst = r;
        i_mem_ready = rdy;
        i_zero = z;
        i_op = cur_op;
        i_funct3 = cur_f3;
        i_funct7_5 = cur_f75;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic [1:0] sb, input logic [2:0] alu, input string tag);
        set_instr(op, f3, f75);
        cyc(1, 1, 0, e_fetch(2'b00, 1, 0), {tag, "_fetch"});
        cyc(1, 1, 0, e_decode(2'b00, 0), {tag, "_decode"});
        cyc(1, 1, 0, e_exec(sb, alu), {tag, "_exec"});
        cyc(1, 1, 0, e_aluwb(2'b00), {tag, "_aluwb"});
    endtask

    initial begin : monitor
        outs_t e;
        string n;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, act, e);
                end
            end
        end
    end

    initial begin : driver
        // Reset holds strobes low even with ready asserted.
        cyc(0, 1, 0, e_fetch(2'b00, 0, 0), "reset_0");
        cyc(0, 1, 0, e_fetch(2'b00, 0, 0), "reset_1");

        run_alu(7'b0110011, 3'b000, 1'b0, 2'b00, 3'b000, "add");
        run_alu(7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001, "sub");
        run_alu(7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101, "slt");
        run_alu(7'b0110011, 3'b110, 1'b0, 2'b00, 3'b011, "or");
        run_alu(7'b0110011, 3'b100, 1'b0, 2'b00, 3'b000, "f3_other");
        run_alu(7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000, "addi_f7");
        run_alu(7'b0010011, 3'b111, 1'b0, 2'b01, 3'b010, "andi");

        // lw: three stall cycles, ready on the would-be timeout cycle wins.
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc(1, 1, 0, e_fetch(2'b00, 1, 0), "lw_fetch");
        cyc(1, 1, 0, e_decode(2'b00, 0), "lw_decode");
        cyc(1, 1, 0, e_memadr(2'b00), "lw_memadr");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0), "lw_memread_wait");
        cyc(1, 1, 0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0), "lw_memread_rdy");
        cyc(1, 1, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0), "lw_memwb");

        // sw: store strobe held while waiting, dropped on the timeout cycle.
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc(1, 1, 0, e_fetch(2'b01, 1, 0), "sw_fetch");
        cyc(1, 1, 0, e_decode(2'b01, 0), "sw_decode");
        cyc(1, 1, 0, e_memadr(2'b01), "sw_memadr");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, e_memwrite(1, 0), "sw_memwrite_wait");
        cyc(1, 0, 0, e_memwrite(0, 1), "sw_timeout");
        cyc(1, 1, 0, e_fetch(2'b01, 1, 0), "sw_after_timeout");

        // Reset in the middle of a store.
        cyc(1, 1, 0, e_decode(2'b01, 0), "sw2_decode");
        cyc(1, 1, 0, e_memadr(2'b01), "sw2_memadr");
        cyc(1, 0, 0, e_memwrite(1, 0), "sw2_memwrite");
        cyc(0, 0, 0, e_fetch(2'b01, 0, 0), "rst_mid_store");
        cyc(0, 1, 0, e_fetch(2'b01, 0, 0), "rst_hold");
        cyc(1, 1, 0, e_fetch(2'b01, 1, 0), "post_rst_fetch");
        cyc(1, 1, 0, e_decode(2'b01, 0), "post_rst_decode");
        cyc(1, 1, 0, e_memadr(2'b01), "sw3_memadr");
        cyc(1, 1, 0, e_memwrite(1, 0), "sw3_memwrite_rdy");

        set_instr(7'b1100011, 3'b000, 1'b0);
        cyc(1, 1, 0, e_fetch(2'b10, 1, 0), "beq_fetch");
        cyc(1, 1, 0, e_decode(2'b10, 0), "beq_decode");
        cyc(1, 1, 1, e_beq(1), "beq_taken");
        cyc(1, 1, 0, e_fetch(2'b10, 1, 0), "beq2_fetch");
        cyc(1, 1, 0, e_decode(2'b10, 0), "beq2_decode");
        cyc(1, 1, 0, e_beq(0), "beq_not_taken");

        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc(1, 1, 0, e_fetch(2'b11, 1, 0), "jal_fetch");
        cyc(1, 1, 0, e_decode(2'b11, 0), "jal_decode");
        cyc(1, 1, 0, mk(1, 0, 0, 0, 0, 2'b11, 2'b01, 2'b10, 3'b000, 2'b00, 0, 0), "jal_exec");
        cyc(1, 1, 0, e_aluwb(2'b11), "jal_aluwb");

        set_instr(7'b1111111, 3'b000, 1'b0);
        cyc(1, 1, 0, e_fetch(2'b00, 1, 0), "ill_fetch");
        cyc(1, 1, 0, e_decode(2'b00, 1), "ill_decode");

        // Fetch stalls: bus error on the 4th and 8th stall cycles, then a normal fetch.
        for (int i = 1; i <= 8; i++)
            cyc(1, 0, 0, e_fetch(2'b00, 0, (i == 4) || (i == 8)), "fetch_stall");
        cyc(1, 1, 0, e_fetch(2'b00, 1, 0), "fetch_recover");

        repeat (3) @(negedge i_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
